// File: rtl/dlfloat_pkg.sv
// Shared DLFloat (1/6/9, bias 31) constants and dot-product sequencer state encoding.
package dlfloat_pkg;

  localparam int unsigned DLF_W    = 16;
  localparam int unsigned DLF_BIAS = 31;

  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
  localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
  localparam logic [DLF_W-1:0] DLF_ONE  = 16'h3E00;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StLoad,
    StDrain,
    StDone
  } seq_state_e;

  function automatic logic dlf_is_nan(input logic [DLF_W-1:0] x);
    return x == DLF_NAN;
  endfunction

endpackage

// File: rtl/dlfloat_dot_seq.sv
// Framed dot-product sequencer: clears the DLFloat MAC, streams LEN operand pairs into it,
// waits out the MAC pipeline, then captures and holds the accumulated result.
module dlfloat_dot_seq
  import dlfloat_pkg::*;
#(
  parameter int unsigned MAC_LAT = 2,
  parameter int unsigned LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_vld,
  output logic             op_rdy,
  input  logic [DLF_W-1:0] op_a,
  input  logic [DLF_W-1:0] op_b,
  output logic [DLF_W-1:0] mac_a,
  output logic [DLF_W-1:0] mac_b,
  output logic             mac_vld,
  output logic             mac_clr,
  input  logic [DLF_W-1:0] mac_acc,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [DLF_W-1:0] res_data,
  output logic             res_nan,
  output logic             busy
);

  localparam int unsigned CNT_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  seq_state_e       state_q, state_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] drain_q, drain_d;
  logic             nan_q, nan_d;
  logic [DLF_W-1:0] mac_a_q, mac_a_d;
  logic [DLF_W-1:0] mac_b_q, mac_b_d;
  logic             mac_vld_q, mac_vld_d;
  logic [DLF_W-1:0] res_data_q, res_data_d;
  logic             res_nan_q, res_nan_d;

  // Ready/valid outputs are pure state decodes so no ready depends on a valid.
  assign cmd_rdy  = (state_q == StIdle);
  assign op_rdy   = (state_q == StLoad);
  assign mac_clr  = (state_q == StClr);
  assign res_vld  = (state_q == StDone);
  assign busy     = (state_q != StIdle);
  assign mac_a    = mac_a_q;
  assign mac_b    = mac_b_q;
  assign mac_vld  = mac_vld_q;
  assign res_data = res_data_q;
  assign res_nan  = res_nan_q;

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    drain_d    = drain_q;
    nan_d      = nan_q;
    mac_a_d    = mac_a_q;
    mac_b_d    = mac_b_q;
    mac_vld_d  = 1'b0;
    res_data_d = res_data_q;
    res_nan_d  = res_nan_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_vld) begin
          if (cmd_len == '0) begin
            res_data_d = DLF_ZERO;
            res_nan_d  = 1'b0;
            state_d    = StDone;
          end else begin
            remain_d = cmd_len;
            nan_d    = 1'b0;
            state_d  = StClr;
          end
        end
      end
      StClr: state_d = StLoad;
      StLoad: begin
        if (op_vld) begin
          mac_a_d   = op_a;
          mac_b_d   = op_b;
          mac_vld_d = 1'b1;
          remain_d  = remain_q - 1'b1;
          nan_d     = nan_q | dlf_is_nan(op_a) | dlf_is_nan(op_b);
          if (remain_q == LEN_W'(1)) begin
            drain_d = CNT_W'(MAC_LAT);
            state_d = StDrain;
          end
        end
      end
      // The last pair is on the MAC while drain_q == MAC_LAT; its sum is visible at zero.
      StDrain: begin
        if (drain_q == '0) begin
          res_data_d = mac_acc;
          res_nan_d  = nan_q;
          state_d    = StDone;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      StDone: begin
        if (res_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      remain_q   <= '0;
      drain_q    <= '0;
      nan_q      <= 1'b0;
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      mac_vld_q  <= 1'b0;
      res_data_q <= '0;
      res_nan_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      drain_q    <= drain_d;
      nan_q      <= nan_d;
      mac_a_q    <= mac_a_d;
      mac_b_q    <= mac_b_d;
      mac_vld_q  <= mac_vld_d;
      res_data_q <= res_data_d;
      res_nan_q  <= res_nan_d;
    end
  end

endmodule
